imm_extender: RTL
=================

# imm_extender

Parametrised, pipelined immediate-extension unit for the CPU datapath; it generalises the fixed combinational sign extender. It accepts IN_SIZE-bit immediate chunks over a valid/ready handshake and applies one of four modes: sign-extend, zero-extend, upper-place or prefix. Prefix chunks accumulate so multi-instruction immediates can be built. It presents a registered OUT_SIZE-bit result to the decode/execute stage.

## Interface
- IN_SIZE, 8, chunk width in bits (≥1)
- OUT_SIZE, 16, result width in bits (≥ IN_SIZE)
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous discard of prefix state and pending output
- in_valid  input  1  chunk offered
- in_ready  output  1  chunk accepted when in_valid && in_ready
- in_data  input  IN_SIZE  immediate chunk
- mode  input  2  00 SIGN, 01 ZERO, 10 UPPER, 11 PREFIX
- out_valid  output  1  result held in output register
- out_ready  input  1  consumer accepts result
- out_data  output  OUT_SIZE  extended immediate
- ovf  output  1  result lost prefix bits (qualified by out_valid)

## Operation
- Accumulator acc[OUT_SIZE-1:0] and count (0..MAXP, MAXP = ceil(OUT_SIZE/IN_SIZE)-1). FSM: IDLE (count=0), PREFIX (count>0).
- PREFIX chunk accepted: acc ← (acc << IN_SIZE) | in_data, count ← count+1 (saturating at MAXP), no output; state → PREFIX.
- Final chunk (mode ≠ 11) accepted: combined = (acc << IN_SIZE) | in_data truncated to OUT_SIZE; eff = min((count+1)·IN_SIZE, OUT_SIZE).
  - SIGN: bits ≥ eff copy bit eff-1. ZERO: bits ≥ eff cleared. UPPER: combined << (OUT_SIZE − eff).
  - Result → out_data, out_valid ← 1; acc, count cleared; state → IDLE.
- in_ready = !flush && (!out_valid || out_ready); one-entry output, simultaneous drain and fill allowed.
- out_valid falls after out_ready handshake unless a new final chunk loads the same cycle.
- flush: acc, count, out_valid, ovf cleared; input that cycle dropped (in_ready low).
- Prefix beyond MAXP: excess high bits shift out of acc.

## Timing
- Reset (asynchronous): out_valid=0, out_data=0, ovf=0, acc=0, count=0, state IDLE; in_ready=1 once reset_n high.
- Latency: final chunk accepted cycle N → out_valid/out_data at N+1.
- Throughput: one result per cycle with out_ready held high; a k-prefix immediate takes k+1 accepted chunks.
- out_data and ovf stable while out_valid && !out_ready.
- Reset mid-prefix discards partial immediate, no output.

## Configuration
- IMM_EXT_OVF_EN defined: sticky overflow bit set when a PREFIX arrives with count = MAXP. It is copied to ovf with the next result and cleared with acc.
- Undefined: no overflow tracking, ovf constant 0; truncation behaviour unchanged.

## Structure
- imm_ext_pkg: mode constants (MODE_SIGN, MODE_ZERO, MODE_UPPER, MODE_PREFIX), 2-bit mode type, state encoding.
- One sub-module: ext_core, combinational extend of combined by dynamic eff and mode. The sequential control, accumulator and output register stay in imm_extender.

## Test plan
- IN=8/OUT=16, SIGN 0x80 → next cycle out_data 0xFF80, out_valid 1; ZERO 0x80 → 0x0080.
- UPPER 0x12 → 0x1200; back-to-back SIGN 0x01, ZERO 0xFF with out_ready=1 → 0x0001 then 0x00FF on consecutive cycles.
- PREFIX 0x12 then SIGN 0x34 → 0x1234, ovf 0. IN=4/OUT=16: PREFIX 0x8, SIGN 0x1 → 0xFF81.
- out_ready=0 after SIGN 0x7F: out_data held 0x007F, in_ready 0. Next chunk stalls until out_ready=1, then loads the following cycle.
- With IMM_EXT_OVF_EN: PREFIX 0x12, PREFIX 0x34, SIGN 0x56 → 0x3456, ovf 1. Next plain SIGN 0x01 → 0x0001, ovf 0.
- PREFIX 0x12 then reset_n pulse (or flush) → SIGN 0x34 yields 0x0034, no stale prefix.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg
//   Shared definitions for the immediate-extension unit:
//   - mode_t / MODE_* : 2-bit extension mode encoding
//   - state_t         : accumulator FSM encoding (IDLE = no prefix held)
//   - calc_maxp()     : highest useful prefix count for a chunk/result width pair
package imm_ext_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SIGN   = 2'b00;
    localparam mode_t MODE_ZERO   = 2'b01;
    localparam mode_t MODE_UPPER  = 2'b10;
    localparam mode_t MODE_PREFIX = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_PREFIX = 1'b1
    } state_t;

    // ceil(out_w / in_w) - 1 : prefixes beyond this push bits off the top
    function automatic int calc_maxp(input int in_w, input int out_w);
        return (out_w + in_w - 1) / in_w - 1;
    endfunction

endpackage

// File: rtl/imm_extender_ext_core.sv
// ext_core
//   Combinational extension of an assembled immediate.
//   Ports:
//     combined_i : assembled immediate (prefix bits + final chunk), OUT_SIZE bits
//     eff_i      : number of meaningful low bits in combined_i (1..OUT_SIZE)
//     mode_i     : SIGN / ZERO / UPPER (PREFIX never reaches here; passes through)
//     result_o   : extended OUT_SIZE-bit result
module ext_core
    import imm_ext_pkg::*;
#(
    parameter int OUT_SIZE = 16,
    parameter int EFF_W    = 5
) (
    input  logic [OUT_SIZE-1:0] combined_i,
    input  logic [EFF_W-1:0]    eff_i,
    input  mode_t               mode_i,
    output logic [OUT_SIZE-1:0] result_o
);

    logic                sign_b;
    logic [OUT_SIZE-1:0] ext;
    logic [OUT_SIZE-1:0] upper;

    always_comb begin
        // pick bit eff-1 with a compare loop so the index never leaves the vector
        sign_b = 1'b0;
        for (int i = 0; i < OUT_SIZE; i++) begin
            if (int'(eff_i) == i + 1) sign_b = combined_i[i];
        end

        ext = '0;
        for (int i = 0; i < OUT_SIZE; i++) begin
            if (i < int'(eff_i)) ext[i] = combined_i[i];
            else                 ext[i] = (mode_i == MODE_SIGN) ? sign_b : 1'b0;
        end

        // left-justify the meaningful bits in the result
        upper = combined_i << (OUT_SIZE - int'(eff_i));

        case (mode_i)
            MODE_SIGN,
            MODE_ZERO:  result_o = ext;
            MODE_UPPER: result_o = upper;
            default:    result_o = combined_i;
        endcase
    end

endmodule

// File: rtl/imm_extender.sv
// imm_extender
//   Pipelined immediate-extension unit. Accepts IN_SIZE-bit chunks over a
//   valid/ready handshake; PREFIX chunks accumulate, any other mode finishes
//   the immediate and loads a one-entry registered output.
//   Parameters: IN_SIZE (chunk width), OUT_SIZE (result width, >= IN_SIZE)
//   Ports:
//     clk, reset_n          : clock, asynchronous active-low reset
//     flush                 : synchronous discard of prefix state and pending output
//     in_valid/in_ready     : input handshake, in_data chunk + mode
//     out_valid/out_ready   : output handshake, out_data result
//     ovf                   : result lost prefix bits (valid with out_valid)
//   Build option: IMM_EXT_OVF_EN enables sticky prefix-overflow tracking;
//   without it ovf is tied low.
module imm_extender
    import imm_ext_pkg::*;
#(
    parameter int IN_SIZE  = 8,
    parameter int OUT_SIZE = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_SIZE-1:0]  in_data,
    input  logic [1:0]          mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_SIZE-1:0] out_data,
    output logic                ovf
);

    localparam int MAXP  = calc_maxp(IN_SIZE, OUT_SIZE);
    localparam int CNT_W = (MAXP > 0) ? $clog2(MAXP + 1) : 1;
    localparam int EFF_W = $clog2(OUT_SIZE + 1);

    state_t              state_q;
    logic [OUT_SIZE-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q;
    logic [OUT_SIZE-1:0] out_data_q, out_data_d;
    logic [EFF_W-1:0]    eff;
    logic                accept, is_prefix, cnt_full;

    assign in_ready  = !flush && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_prefix = (mode == MODE_PREFIX);
    assign cnt_full  = (int'(cnt_q) == MAXP);

    // shift the chunk in below the accumulator; excess high bits fall off
    assign acc_d = OUT_SIZE'({acc_q, in_data});
    assign cnt_d = cnt_full ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        int eff_int;
        eff_int = (state_q == ST_IDLE) ? IN_SIZE : (int'(cnt_q) + 1) * IN_SIZE;
        if (eff_int > OUT_SIZE) eff_int = OUT_SIZE;
        eff = EFF_W'(eff_int);
    end

    ext_core #(
        .OUT_SIZE (OUT_SIZE),
        .EFF_W    (EFF_W)
    ) u_ext_core (
        .combined_i (acc_d),
        .eff_i      (eff),
        .mode_i     (mode),
        .result_o   (out_data_d)
    );

`ifdef IMM_EXT_OVF_EN
    logic sticky_q;
    logic ovf_q;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef IMM_EXT_OVF_EN
            sticky_q    <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else if (flush) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef IMM_EXT_OVF_EN
            sticky_q    <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            if (accept) begin
                if (is_prefix) begin
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_d;
                    state_q <= ST_PREFIX;
`ifdef IMM_EXT_OVF_EN
                    if (cnt_full) sticky_q <= 1'b1;
`endif
                end else begin
                    // a final load wins over a same-cycle drain
                    out_data_q  <= out_data_d;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    state_q     <= ST_IDLE;
`ifdef IMM_EXT_OVF_EN
                    ovf_q       <= sticky_q;
                    sticky_q    <= 1'b0;
`endif
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
